pipe_inst_issuer: RTL and testbench
===================================

Name: pipe_inst_issuer

Overview:
Instruction source for the simple 4-register pipeline: drives that pipeline's inst/inst_valid inputs and honours its inst_ready output. Holds a small program buffer loaded through a write port. On start, it issues the stored program in order at up to one instruction per cycle under a stable-valid handshake. It supports pause and deferred abort, and counts issued and register-writing instructions for bench scoreboarding.

Parameters:
DEPTH, 8, number of program slots (power of two, >=2)
AW, 3, log2(DEPTH); address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
prog_we  input  1  program write strobe
prog_addr  input  AW  program slot address
prog_data  input  8  instruction word {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}
prog_len  input  AW+1  number of instructions to issue, sampled on start; range 0..DEPTH
start  input  1  begin issuing from slot 0
abort  input  1  stop issuing after any pending offer completes
pause  input  1  suppress new offers while high
inst  output  8  instruction offered to pipeline
inst_valid  output  1  offer valid
inst_ready  input  1  pipeline accepts (handshake = inst_valid && inst_ready)
busy  output  1  state is RUN
done  output  1  state is DONE
issued_cnt  output  AW+1  handshakes completed since last start
wr_inst_cnt  output  AW+1  issued instructions with op != 2'b00 (ADD/SET/NAND)

Behaviour:
- Reset (rst=0, async): state=IDLE; inst_valid=0; inst=8'h00; busy=0; done=0; pc=0; len=0; issued_cnt=0; wr_inst_cnt=0; abort_pend=0. Program memory is not reset; its contents are undefined until written.
- All outputs are registered. inst and inst_valid come from flops; there is no combinational path from inst_ready to any output.
- Program write: a write happens on a clock edge when prog_we=1 and state!=RUN, storing mem[prog_addr]<=prog_data. prog_we is ignored in RUN.
- FSM states are IDLE, RUN, DONE.
  - IDLE/DONE + start=1 with prog_len==0: no state change; done and counters unchanged.
  - IDLE/DONE + start=1 with prog_len in 1..DEPTH: next state RUN. Latch len=prog_len; pc=0; clear issued_cnt, wr_inst_cnt, done and abort_pend. If pause=0, inst_valid=1 and inst=mem[0] in the next cycle (1-cycle latency).
  - start in RUN is ignored.
  - RUN to DONE happens on the cycle after the handshake of slot len-1, or when abort_pend is set and no offer is pending. DONE holds done=1 until the next accepted start.
  - prog_len>DEPTH is clamped to DEPTH.
- Offer rule, evaluated each cycle in RUN where an offer slot is free (inst_valid=0 or handshake this cycle):
  - Next offer exists iff pc_next<len, pause=0, abort=0 and abort_pend=0. Then inst_valid<=1 and inst<=mem[pc_next]. Otherwise inst_valid<=0.
  - pc_next = pc+1 on handshake, else pc.
  - Back-to-back handshakes sustain 1 instruction per cycle.
- Stability: once inst_valid=1, inst and inst_valid hold unchanged until the handshake. pause, abort and prog_we never retract or alter a pending offer.
- On each handshake: pc+=1; issued_cnt+=1; wr_inst_cnt+=1 if inst[7:6]!=2'b00.
- abort in RUN:
  - If no offer is pending, or a handshake occurs the same cycle, go to DONE next cycle with no further offer.
  - Otherwise set abort_pend; DONE follows the cycle after the pending handshake.
- abort outside RUN is ignored.
- pause=1 with an offer pending: the offer stays. pause deasserting re-enables offers in the next cycle.
- Counters cannot overflow: each is at most len<=DEPTH.
- Asynchronous reset mid-RUN drops inst_valid immediately and returns to IDLE. Program memory contents are retained.

Test Plan:
- Load slots 0..3 = 8'h84, 8'h45, 8'h9A, 8'h00; start with prog_len=4; inst_ready=1 constant -> inst_valid high for 4 consecutive cycles from start+1 with inst 84, 45, 9A, 00; done=1 next cycle; issued_cnt=4; wr_inst_cnt=3.
- Same program with inst_ready low for 3 cycles while inst=8'h45 is offered -> inst stays 45 and inst_valid stays 1 throughout; the sequence completes with issued_cnt=4.
- Raise pause in the cycle of the slot-0 handshake and hold it 2 cycles -> inst_valid=0 for 2 cycles, then slot 1 is offered. Raise pause while an offer is pending and inst_ready=0 -> the offer is held.
- Assert abort while slot 1 is pending with inst_ready=0; raise inst_ready 2 cycles later -> slot 1 is accepted, no slot 2 offer follows, DONE with issued_cnt=2.
- start with prog_len=0 -> remains IDLE, inst_valid=0. prog_we during RUN -> memory unchanged, verified by a rerun. start with prog_len=9 (DEPTH=8) -> exactly 8 issued.
- Pull rst low mid-RUN after 2 handshakes -> inst_valid, busy and counters are 0 immediately. start again -> program reissued from slot 0.

Source files
------------

// File: rtl/pipe_inst_issuer_if.sv
// Instruction handshake between the issuer and the 4-register pipeline.
// The master modport offers inst/inst_valid; the slave returns inst_ready.
interface pipe_inst_issuer_if;
    logic [7:0] inst;
    logic       inst_valid;
    logic       inst_ready;

    modport master (output inst, output inst_valid, input inst_ready);
    modport slave  (input inst, input inst_valid, output inst_ready);
endinterface

// File: rtl/pipe_inst_issuer.sv
// Program buffer plus issue FSM that feeds the pipeline one instruction per cycle
// under a stable-valid handshake, with pause, deferred abort and issue counters.
module pipe_inst_issuer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [7:0]            prog_data,
    input  logic [AW:0]           prog_len,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    pipe_inst_issuer_if.master    pipe,
    output logic                  busy,
    output logic                  done,
    output logic [AW:0]           issued_cnt,
    output logic [AW:0]           wr_inst_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    state_t      state;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] pc;
    logic [AW:0] len;
    logic        abort_pend;

    logic        hs;
    logic        slot_free;
    logic [AW:0] pc_next;
    logic        finish;

    always_comb begin
        hs        = pipe.inst_valid && pipe.inst_ready;
        slot_free = !pipe.inst_valid || hs;
        pc_next   = hs ? pc + ONE : pc;
        // Leave RUN after the last handshake, or once an abort has no offer left to wait for.
        finish    = (hs && (pc_next == len))
                 || (abort && slot_free)
                 || (abort_pend && slot_free);
    end

    always_ff @(posedge clk) begin
        if (prog_we && (state != RUN))
            mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            pipe.inst_valid <= 1'b0;
            pipe.inst       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pc              <= '0;
            len             <= '0;
            issued_cnt      <= '0;
            wr_inst_cnt     <= '0;
            abort_pend      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && (prog_len != '0)) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        len         <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
                        pc          <= '0;
                        issued_cnt  <= '0;
                        wr_inst_cnt <= '0;
                        abort_pend  <= 1'b0;
                        if (!pause) begin
                            pipe.inst_valid <= 1'b1;
                            pipe.inst       <= mem[0];
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        pc         <= pc_next;
                        issued_cnt <= issued_cnt + ONE;
                        if (pipe.inst[7:6] != 2'b00)
                            wr_inst_cnt <= wr_inst_cnt + ONE;
                    end
                    if (finish) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        pipe.inst_valid <= 1'b0;
                        abort_pend      <= 1'b0;
                    end else begin
                        // Reaching here with abort high implies an offer is still pending.
                        if (abort)
                            abort_pend <= 1'b1;
                        if (slot_free) begin
                            if ((pc_next < len) && !pause) begin
                                pipe.inst_valid <= 1'b1;
                                pipe.inst       <= mem[pc_next[AW-1:0]];
                            end else begin
                                pipe.inst_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_inst_issuer.sv
// Directed and randomized checks of pipe_inst_issuer against a transaction-level
// model: the expected issue stream is simply the first min(prog_len,8) program words.
module tb_pipe_inst_issuer;
    logic       clk = 1'b0;
    logic       rst;
    logic       prog_we;
    logic [2:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] prog_len;
    logic       start;
    logic       abort;
    logic       pause;
    logic       busy;
    logic       done;
    logic [3:0] issued_cnt;
    logic [3:0] wr_inst_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [8];

    pipe_inst_issuer_if ifc ();

    pipe_inst_issuer #(.DEPTH(8), .AW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
        .abort       (abort),
        .pause       (pause),
        .pipe        (ifc),
        .busy        (busy),
        .done        (done),
        .issued_cnt  (issued_cnt),
        .wr_inst_cnt (wr_inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input int addr, input logic [7:0] data);
        prog_we   = 1'b1;
        prog_addr = 3'(addr);
        prog_data = data;
        model_mem[addr] = data;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    // Start a run with random ready/pause and compare every handshake with the model.
    task automatic run_model(input int plen, input string tag);
        int         n;
        int         idx;
        int         exp_wr;
        logic       prev_pend;
        logic [7:0] prev_inst;
        logic [7:0] expq [$];
        n      = (plen > 8) ? 8 : plen;
        exp_wr = 0;
        for (int i = 0; i < n; i++) begin
            expq.push_back(model_mem[i]);
            if (model_mem[i][7:6] != 2'b00) exp_wr++;
        end
        prog_len = 4'(plen);
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (n == 0) begin
            tick();
            chk({tag, "_len0_busy"}, {31'b0, busy}, 32'd0);
            chk({tag, "_len0_valid"}, {31'b0, ifc.inst_valid}, 32'd0);
            return;
        end
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        idx       = 0;
        prev_pend = 1'b0;
        prev_inst = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) break;
            if (prev_pend) begin
                chk({tag, "_hold_valid"}, {31'b0, ifc.inst_valid}, 32'd1);
                chk({tag, "_hold_inst"}, {24'b0, ifc.inst}, {24'b0, prev_inst});
            end
            ifc.inst_ready = ($urandom_range(0, 3) != 0);
            pause          = ($urandom_range(0, 4) == 0);
            if (ifc.inst_valid && ifc.inst_ready) begin
                chk({tag, "_inst"}, {24'b0, ifc.inst}, (idx < n) ? {24'b0, expq[idx]} : 32'hDEAD);
                idx++;
            end
            prev_pend = ifc.inst_valid && !ifc.inst_ready;
            prev_inst = ifc.inst;
            tick();
        end
        pause = 1'b0;
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_count"}, 32'(idx), 32'(n));
        chk({tag, "_issued"}, {28'b0, issued_cnt}, 32'(n));
        chk({tag, "_wr"}, {28'b0, wr_inst_cnt}, 32'(exp_wr));
        chk({tag, "_valid_end"}, {31'b0, ifc.inst_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start = 1'b0; abort = 1'b0; pause = 1'b0; ifc.inst_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'b0, ifc.inst_valid}, 32'd0);
        chk("rst_inst", {24'b0, ifc.inst}, 32'h00);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_issued", {28'b0, issued_cnt}, 32'd0);
        chk("rst_wr", {28'b0, wr_inst_cnt}, 32'd0);
        rst = 1'b1;
        tick();

        prog_write(0, 8'h84); prog_write(1, 8'h45); prog_write(2, 8'h9A); prog_write(3, 8'h00);

        // Full-rate issue with inst_ready held high.
        ifc.inst_ready = 1'b1; prog_len = 4'd4; start = 1'b1;
        tick(); start = 1'b0;
        chk("b2b_v0", {31'b0, ifc.inst_valid}, 32'd1); chk("b2b_i0", {24'b0, ifc.inst}, 32'h84);
        tick(); chk("b2b_v1", {31'b0, ifc.inst_valid}, 32'd1); chk("b2b_i1", {24'b0, ifc.inst}, 32'h45);
        tick(); chk("b2b_v2", {31'b0, ifc.inst_valid}, 32'd1); chk("b2b_i2", {24'b0, ifc.inst}, 32'h9A);
        tick(); chk("b2b_v3", {31'b0, ifc.inst_valid}, 32'd1); chk("b2b_i3", {24'b0, ifc.inst}, 32'h00);
        tick();
        chk("b2b_done", {31'b0, done}, 32'd1);
        chk("b2b_vend", {31'b0, ifc.inst_valid}, 32'd0);
        chk("b2b_issued", {28'b0, issued_cnt}, 32'd4);
        chk("b2b_wr", {28'b0, wr_inst_cnt}, 32'd3);

        // Backpressure on slot 1.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        ifc.inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_inst", {24'b0, ifc.inst}, 32'h45);
            chk("bp_valid", {31'b0, ifc.inst_valid}, 32'd1);
            tick();
        end
        chk("bp_inst_last", {24'b0, ifc.inst}, 32'h45);
        ifc.inst_ready = 1'b1;
        tick(); chk("bp_i2", {24'b0, ifc.inst}, 32'h9A);
        tick(); chk("bp_i3", {24'b0, ifc.inst}, 32'h00);
        tick();
        chk("bp_done", {31'b0, done}, 32'd1);
        chk("bp_issued", {28'b0, issued_cnt}, 32'd4);

        // Pause across the slot-0 handshake, then pause while an offer is pending.
        start = 1'b1; tick(); start = 1'b0;
        pause = 1'b1;
        tick(); chk("pause_gap0", {31'b0, ifc.inst_valid}, 32'd0);
        tick(); chk("pause_gap1", {31'b0, ifc.inst_valid}, 32'd0);
        pause = 1'b0;
        tick(); chk("pause_resume_v", {31'b0, ifc.inst_valid}, 32'd1);
        chk("pause_resume_i", {24'b0, ifc.inst}, 32'h45);
        ifc.inst_ready = 1'b0; pause = 1'b1;
        tick(); tick();
        chk("pause_hold_v", {31'b0, ifc.inst_valid}, 32'd1);
        chk("pause_hold_i", {24'b0, ifc.inst}, 32'h45);
        pause = 1'b0; ifc.inst_ready = 1'b1;
        tick(); chk("pause_i2", {24'b0, ifc.inst}, 32'h9A);
        wait_done("pause_done");
        chk("pause_issued", {28'b0, issued_cnt}, 32'd4);

        // Deferred abort while slot 1 is pending.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        ifc.inst_ready = 1'b0; abort = 1'b1;
        tick(); abort = 1'b0;
        chk("abort_pend_v", {31'b0, ifc.inst_valid}, 32'd1);
        chk("abort_pend_i", {24'b0, ifc.inst}, 32'h45);
        chk("abort_pend_busy", {31'b0, busy}, 32'd1);
        tick();
        chk("abort_pend_v2", {31'b0, ifc.inst_valid}, 32'd1);
        ifc.inst_ready = 1'b1;
        tick();
        chk("abort_v", {31'b0, ifc.inst_valid}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd1);
        chk("abort_issued", {28'b0, issued_cnt}, 32'd2);
        tick();
        chk("abort_no_more", {31'b0, ifc.inst_valid}, 32'd0);

        // Zero-length start is ignored.
        prog_len = 4'd0; start = 1'b1; tick(); start = 1'b0; tick();
        chk("len0_busy", {31'b0, busy}, 32'd0);
        chk("len0_valid", {31'b0, ifc.inst_valid}, 32'd0);
        chk("len0_issued", {28'b0, issued_cnt}, 32'd2);

        // Writes during RUN must not reach memory; the rerun proves slot 1 unchanged.
        ifc.inst_ready = 1'b0; prog_len = 4'd4; start = 1'b1; tick(); start = 1'b0;
        prog_we = 1'b1; prog_addr = 3'd1; prog_data = 8'hFF;
        tick(); tick();
        prog_we = 1'b0; ifc.inst_ready = 1'b1;
        wait_done("we_run_done");
        run_model(4, "rerun");

        // Clamp above DEPTH.
        for (int i = 4; i < 8; i++) prog_write(i, 8'($urandom));
        run_model(9, "clamp");

        // Asynchronous reset mid-run after two handshakes.
        ifc.inst_ready = 1'b1; pause = 1'b0; prog_len = 4'd4; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        chk("pre_rst_issued", {28'b0, issued_cnt}, 32'd2);
        rst = 1'b0; #1;
        chk("arst_valid", {31'b0, ifc.inst_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_issued", {28'b0, issued_cnt}, 32'd0);
        chk("arst_wr", {28'b0, wr_inst_cnt}, 32'd0);
        #2 rst = 1'b1;
        tick();
        run_model(4, "post_rst");

        // Random programs and lengths.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) prog_write(i, 8'($urandom));
            run_model(int'($urandom_range(0, 9)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
